// File: rtl/mtc_ppa_pkg.sv
// Shared mTC-PPA definitions: encoder state and the one-hot to thermometer helper
// used by both the grant encoder and the grant converter benches.
package mtc_ppa_pkg;

    localparam int MTC_MAX_W = 64;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_BUSY  = 1'b1
    } gnt_enc_state_e;

    // Prefix-OR from bit 0 upward: one-hot k becomes ones at every j >= k.
    function automatic logic [MTC_MAX_W-1:0] thermo_from_onehot(input logic [MTC_MAX_W-1:0] oh);
        logic [MTC_MAX_W-1:0] t;
        t    = '0;
        t[0] = oh[0];
        for (int j = 1; j < MTC_MAX_W; j++)
            t[j] = t[j-1] | oh[j];
        return t;
    endfunction

endpackage

// File: rtl/mtc_ppa_lsb_splitter.sv
// Peels up to AMOUNT_M lowest set bits off a vector, one per slot, packed from slot 0.
module mtc_ppa_lsb_splitter
    import mtc_ppa_pkg::*;
#(
    parameter int WIDTH_N  = 2,
    parameter int AMOUNT_M = 1
) (
    input  logic [WIDTH_N-1:0]               vec,
    output logic [AMOUNT_M-1:0][WIDTH_N-1:0] slot_oh,
    output logic [AMOUNT_M-1:0]              slot_mask,
    output logic [WIDTH_N-1:0]               taken_bits
);

    always_comb begin
        logic [WIDTH_N-1:0] rem;
        logic [WIDTH_N-1:0] lsb;
        rem       = vec;
        lsb       = '0;
        slot_oh   = '0;
        slot_mask = '0;
        for (int i = 0; i < AMOUNT_M; i++) begin
            lsb          = rem & (~rem + WIDTH_N'(1));
            slot_oh[i]   = lsb;
            slot_mask[i] = |lsb;
            rem          = rem & ~lsb;
        end
        taken_bits = vec & ~rem;
    end

endmodule

// File: rtl/mtc_ppa_gnt_encoder.sv
// Multi-hot grant vector -> AMOUNT_M thermometer slots per beat, split over
// several beats (lowest bits first) when more than AMOUNT_M bits are set.
module mtc_ppa_gnt_encoder
    import mtc_ppa_pkg::*;
#(
    parameter int WIDTH_N  = 2,
    parameter int AMOUNT_M = 1
) (
    input  logic                             clk,
    input  logic                             reset_n,
    input  logic [WIDTH_N-1:0]               in_gnt_i,
    input  logic                             in_gnt_vld_i,
    output logic                             in_gnt_rdy_o,
    output logic [AMOUNT_M-1:0][WIDTH_N-1:0] out_gnt_o,
    output logic [AMOUNT_M-1:0]              out_slot_vld_o,
    output logic                             out_last_o,
    output logic                             out_gnt_vld_o,
    input  logic                             out_gnt_rdy_i
);

    gnt_enc_state_e state_q, state_d;

    logic [WIDTH_N-1:0]               residual_q;
    logic [WIDTH_N-1:0]               src;
    logic [WIDTH_N-1:0]               taken;
    logic [WIDTH_N-1:0]               rem_next;
    logic [AMOUNT_M-1:0][WIDTH_N-1:0] slot_oh;
    logic [AMOUNT_M-1:0][WIDTH_N-1:0] slot_th;
    logic [AMOUNT_M-1:0]              slot_mask;
    logic                             accept, advance, drain, load;

    // Ready may look through to out_gnt_rdy_i so the last beat hands off with no bubble.
    assign in_gnt_rdy_o = !out_gnt_vld_o | (out_gnt_rdy_i & out_last_o);
    assign accept       = in_gnt_vld_i & in_gnt_rdy_o;
    assign advance      = out_gnt_vld_o & out_gnt_rdy_i & !out_last_o;
    assign drain        = out_gnt_vld_o & out_gnt_rdy_i & out_last_o & !accept;
    assign load         = accept | advance;

    assign src      = accept ? in_gnt_i : residual_q;
    assign rem_next = src & ~taken;

    mtc_ppa_lsb_splitter #(
        .WIDTH_N  (WIDTH_N),
        .AMOUNT_M (AMOUNT_M)
    ) u_split (
        .vec        (src),
        .slot_oh    (slot_oh),
        .slot_mask  (slot_mask),
        .taken_bits (taken)
    );

    for (genvar i = 0; i < AMOUNT_M; i++) begin : g_slot
        assign slot_th[i] = WIDTH_N'(thermo_from_onehot(MTC_MAX_W'(slot_oh[i])));
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state_q <= ST_EMPTY;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (load)       state_d = ST_BUSY;
        else if (drain) state_d = ST_EMPTY;
    end

    always_comb begin
        out_gnt_vld_o = (state_q == ST_BUSY);
    end

    // Beat registers only move on a load, which keeps them stable under backpressure.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            residual_q     <= '0;
            out_gnt_o      <= '0;
            out_slot_vld_o <= '0;
            out_last_o     <= 1'b0;
        end else if (load) begin
            residual_q     <= rem_next;
            out_gnt_o      <= slot_th;
            out_slot_vld_o <= slot_mask;
            out_last_o     <= (rem_next == '0);
        end
    end

endmodule

// File: tb/tb_mtc_ppa_gnt_encoder.sv
// Directed and round-trip bench for mtc_ppa_gnt_encoder at WIDTH_N=8, AMOUNT_M=2.
module tb_mtc_ppa_gnt_encoder;

    localparam int W = 8;
    localparam int M = 2;
    localparam int NVEC = 200;

    logic                 clk = 1'b0;
    logic                 reset_n;
    logic [W-1:0]         in_gnt_i;
    logic                 in_gnt_vld_i;
    logic                 in_gnt_rdy_o;
    logic [M-1:0][W-1:0]  out_gnt_o;
    logic [M-1:0]         out_slot_vld_o;
    logic                 out_last_o;
    logic                 out_gnt_vld_o;
    logic                 out_gnt_rdy_i;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    mtc_ppa_gnt_encoder #(.WIDTH_N(W), .AMOUNT_M(M)) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .in_gnt_i       (in_gnt_i),
        .in_gnt_vld_i   (in_gnt_vld_i),
        .in_gnt_rdy_o   (in_gnt_rdy_o),
        .out_gnt_o      (out_gnt_o),
        .out_slot_vld_o (out_slot_vld_o),
        .out_last_o     (out_last_o),
        .out_gnt_vld_o  (out_gnt_vld_o),
        .out_gnt_rdy_i  (out_gnt_rdy_i)
    );

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h want %0h", tag, act, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_beat(input string tag, input logic [15:0] gnt, input logic [1:0] sv, input logic last);
        chk({tag, ".vld"},  out_gnt_vld_o, 1'b1);
        chk({tag, ".gnt"},  out_gnt_o, gnt);
        chk({tag, ".slot"}, out_slot_vld_o, sv);
        chk({tag, ".last"}, out_last_o, last);
    endtask

    logic [W-1:0]  q[$];
    logic [W-1:0]  acc, exp_v, th;
    logic [19:0]   snap;
    logic          stall_prev, acc_prev;
    int            beats, done, issued, cyc, pop, expb;

    initial begin
        reset_n       = 1'b0;
        in_gnt_i      = '0;
        in_gnt_vld_i  = 1'b0;
        out_gnt_rdy_i = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst.vld",  out_gnt_vld_o, 1'b0);
        chk("rst.gnt",  out_gnt_o, 16'h0);
        chk("rst.slot", out_slot_vld_o, 2'b00);
        chk("rst.last", out_last_o, 1'b0);
        chk("rst.rdy",  in_gnt_rdy_o, 1'b1);
        @(negedge clk) reset_n = 1'b1;
        step;

        // Two bits: one beat
        in_gnt_i = 8'b0010_0100; in_gnt_vld_i = 1'b1;
        #1 chk("two.rdy", in_gnt_rdy_o, 1'b1);
        step; in_gnt_vld_i = 1'b0;
        chk_beat("two", 16'hE0FC, 2'b11, 1'b1);
        step;
        chk("two.drain", out_gnt_vld_o, 1'b0);

        // Four bits: two beats, input stalled during beat 0
        in_gnt_i = 8'b1011_0001; in_gnt_vld_i = 1'b1;
        step; in_gnt_vld_i = 1'b0;
        chk_beat("four.b0", 16'hF0FF, 2'b11, 1'b0);
        chk("four.rdy0", in_gnt_rdy_o, 1'b0);
        step;
        chk_beat("four.b1", 16'h80E0, 2'b11, 1'b1);
        step;
        chk("four.drain", out_gnt_vld_o, 1'b0);

        // One bit, then zero vector back to back
        in_gnt_i = 8'h08; in_gnt_vld_i = 1'b1;
        step;
        chk_beat("one", 16'h00F8, 2'b01, 1'b1);
        in_gnt_i = 8'h00;
        #1 chk("one.rdy", in_gnt_rdy_o, 1'b1);
        step; in_gnt_vld_i = 1'b0;
        chk_beat("zero", 16'h0000, 2'b00, 1'b1);
        step;
        chk("zero.drain", out_gnt_vld_o, 1'b0);

        // Backpressure on four-bit vector, next input waiting
        out_gnt_rdy_i = 1'b0;
        in_gnt_i = 8'b1011_0001; in_gnt_vld_i = 1'b1;
        step;
        in_gnt_i = 8'h08;
        for (int k = 0; k < 3; k++) begin
            chk_beat("bp.hold", 16'hF0FF, 2'b11, 1'b0);
            chk("bp.rdy", in_gnt_rdy_o, 1'b0);
            step;
        end
        out_gnt_rdy_i = 1'b1;
        #1 chk("bp.rdy_b0", in_gnt_rdy_o, 1'b0);
        step;
        chk_beat("bp.b1", 16'h80E0, 2'b11, 1'b1);
        chk("bp.handoff_rdy", in_gnt_rdy_o, 1'b1);
        step; in_gnt_vld_i = 1'b0;
        chk_beat("bp.next", 16'h00F8, 2'b01, 1'b1);
        step;
        chk("bp.drain", out_gnt_vld_o, 1'b0);

        // Reset in the middle of a four-beat vector
        in_gnt_i = 8'hFF; in_gnt_vld_i = 1'b1;
        step; in_gnt_vld_i = 1'b0;
        chk_beat("mid.b0", 16'hFEFF, 2'b11, 1'b0);
        #2 reset_n = 1'b0;
        #1;
        chk("mid.vld",  out_gnt_vld_o, 1'b0);
        chk("mid.gnt",  out_gnt_o, 16'h0);
        chk("mid.slot", out_slot_vld_o, 2'b00);
        chk("mid.last", out_last_o, 1'b0);
        @(negedge clk) reset_n = 1'b1;
        step;
        chk("mid.rdy", in_gnt_rdy_o, 1'b1);
        for (int k = 0; k < 4; k++) begin
            chk("mid.quiet", out_gnt_vld_o, 1'b0);
            step;
        end

        // Random round-trip with random ready on both sides
        acc = '0; beats = 0; done = 0; issued = 0; cyc = 0;
        stall_prev = 1'b0; acc_prev = 1'b0; snap = '0;
        while (done < NVEC && cyc < 20000) begin
            @(posedge clk); #1; cyc++;
            if (stall_prev)
                chk("rnd.hold", {out_gnt_o, out_slot_vld_o, out_last_o, out_gnt_vld_o}, snap);
            if (acc_prev) in_gnt_vld_i = 1'b0;
            if (!in_gnt_vld_i && issued < NVEC && $urandom_range(1) == 1) begin
                in_gnt_i     = W'($urandom);
                in_gnt_vld_i = 1'b1;
            end
            out_gnt_rdy_i = ($urandom_range(3) != 0);
            #1;
            acc_prev = in_gnt_vld_i & in_gnt_rdy_o;
            if (acc_prev) begin
                q.push_back(in_gnt_i);
                issued++;
            end
            if (out_gnt_vld_o && out_gnt_rdy_i) begin
                for (int i = 0; i < M; i++) begin
                    th = out_gnt_o[i];
                    if (out_slot_vld_o[i]) acc = acc | (th ^ (th << 1));
                    else                   chk("rnd.pad", th, 8'h00);
                end
                beats++;
                if (out_last_o) begin
                    if (q.size() == 0) begin
                        chk("rnd.spurious", 1'b1, 1'b0);
                    end else begin
                        exp_v = q.pop_front();
                        pop   = $countones(exp_v);
                        expb  = (pop == 0) ? 1 : (pop + M - 1) / M;
                        chk("rnd.roundtrip", acc, exp_v);
                        chk("rnd.beats", beats, expb);
                    end
                    done++;
                    acc   = '0;
                    beats = 0;
                end
            end
            stall_prev = out_gnt_vld_o & !out_gnt_rdy_i;
            snap       = {out_gnt_o, out_slot_vld_o, out_last_o, out_gnt_vld_o};
        end
        chk("rnd.done", done, NVEC);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
